// File: rtl/clz_skip_divider.sv
`default_nettype none
// ============================================================================
// Module   : clz_skip_divider
// Brief    : Iterative unsigned restoring divider that uses the operands'
//            leading-zero counts to skip iterations that cannot yield bits.
// Revision : 1.0 - initial release
// ============================================================================
module clz_skip_divider #(
  parameter int DIV_WIDTH = 32,
  parameter int CLZ_WIDTH = $clog2(DIV_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DIV_WIDTH-1:0] dividend,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic [CLZ_WIDTH-1:0] dividend_CLZ,
  input  logic [CLZ_WIDTH-1:0] divisor_CLZ,
  input  logic                 divisor_is_zero,
  output logic [DIV_WIDTH-1:0] quotient,
  output logic [DIV_WIDTH-1:0] remainder,
  output logic                 done
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_accept;
  logic                 w_trivial;
  logic [CLZ_WIDTH-1:0] w_shift;
  logic [DIV_WIDTH:0]   w_diff;

  logic [DIV_WIDTH-1:0] r_quot;
  logic [DIV_WIDTH-1:0] r_rem;
  logic [DIV_WIDTH-1:0] r_adiv;
  logic [CLZ_WIDTH-1:0] r_count;
  logic                 r_done;

  assign w_trivial = (divisor_CLZ < dividend_CLZ);
  assign w_shift   = divisor_CLZ - dividend_CLZ;
  // Extra top bit acts as the borrow: set means the trial subtraction failed.
  assign w_diff    = {1'b0, r_rem} - {1'b0, r_adiv};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          if (!divisor_is_zero && !w_trivial) begin
            w_state_next = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (r_count == '0) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_quot  <= '0;
      r_rem   <= '0;
      r_adiv  <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      assert (!(start && r_state == S_RUN))
        else $warning("clz_skip_divider: start during RUN ignored");
      if (w_accept) begin
        r_rem <= dividend;
        if (divisor_is_zero) begin
          r_quot <= '1;
          r_done <= 1'b1;
        end else if (w_trivial) begin
          r_quot <= '0;
          r_done <= 1'b1;
        end else begin
          // shift <= divisor_CLZ, so no set bit of the divisor is lost.
          r_quot  <= '0;
          r_adiv  <= divisor << w_shift;
          r_count <= w_shift;
        end
      end else if (r_state == S_RUN) begin
        if (!w_diff[DIV_WIDTH]) begin
          r_rem <= w_diff[DIV_WIDTH-1:0];
        end
        r_quot <= {r_quot[DIV_WIDTH-2:0], ~w_diff[DIV_WIDTH]};
        r_adiv <= r_adiv >> 1;
        if (r_count == '0) begin
          r_done <= 1'b1;
        end else begin
          r_count <= r_count - 1'b1;
        end
      end
    end
  end

  assign quotient  = r_quot;
  assign remainder = r_rem;
  assign done      = r_done;

endmodule
`default_nettype wire
